// File: rtl/inst_mem_if.sv
// inst_mem_if: load port, fetch port and core-control signals of inst_mem_server.
interface inst_mem_if #(parameter int AW = 6) ();
  logic          load_start;
  logic [7:0]    ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] add;
  logic [31:0]   inst;
  logic          cpu_rst;
  logic          load_done;
  logic          ld_err;
  logic [AW:0]   ld_count;
  modport master (output load_start, ld_data, ld_valid, add,
                  input ld_ready, inst, cpu_rst, load_done, ld_err, ld_count);
  modport slave  (input load_start, ld_data, ld_valid, add,
                  output ld_ready, inst, cpu_rst, load_done, ld_err, ld_count);
endinterface

// File: rtl/inst_mem_server.sv
// inst_mem_server: byte-loaded 64-byte program store with big-endian fetch and core reset control.
// Define INST_MEM_CHECKSUM_EN to require a trailing XOR checksum byte and enable the ERR state.
module inst_mem_server #(
  parameter int AW = 6,
  parameter int DEPTH = 1 << AW
) (
  input  logic     clk,
  input  logic     rst_master,
  inst_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;
  state_t state_q, state_d;
  logic [AW:0] ld_count_q, ld_count_d;
  logic [7:0] mem_q [DEPTH];
  logic we;
`ifdef INST_MEM_CHECKSUM_EN
  localparam logic [AW:0] SUM_IDX = (AW+1)'(DEPTH);
  logic [7:0] xor_q, xor_d;
`else
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
`endif
  always_comb begin
    state_d = state_q;
    ld_count_d = ld_count_q;
    we = 1'b0;
`ifdef INST_MEM_CHECKSUM_EN
    xor_d = xor_q;
`endif
    if (bus.load_start) begin
      state_d = LOAD;
      ld_count_d = '0;
`ifdef INST_MEM_CHECKSUM_EN
      xor_d = '0;
`endif
    end else if (state_q == LOAD && bus.ld_valid) begin
      ld_count_d = ld_count_q + 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
      if (ld_count_q == SUM_IDX) begin
        state_d = (bus.ld_data == xor_q) ? RUN : ERR;
      end else begin
        we = 1'b1;
        xor_d = xor_q ^ bus.ld_data;
      end
`else
      we = 1'b1;
      state_d = (ld_count_q == LAST_IDX) ? RUN : LOAD;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst_master) begin
    if (rst_master) begin
      state_q <= IDLE;
      ld_count_q <= '0;
`ifdef INST_MEM_CHECKSUM_EN
      xor_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ld_count_q <= ld_count_d;
`ifdef INST_MEM_CHECKSUM_EN
      xor_q <= xor_d;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst_master) begin
    if (rst_master) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[ld_count_q[AW-1:0]] <= bus.ld_data;
    end
  end
  // Byte offsets wrap naturally in the AW-bit address arithmetic.
  assign bus.inst = {mem_q[bus.add], mem_q[bus.add + AW'(1)],
                     mem_q[bus.add + AW'(2)], mem_q[bus.add + AW'(3)]};
  assign bus.ld_ready  = state_q == LOAD;
  assign bus.cpu_rst   = state_q != RUN;
  assign bus.load_done = state_q == RUN;
  assign bus.ld_count  = ld_count_q;
`ifdef INST_MEM_CHECKSUM_EN
  assign bus.ld_err = state_q == ERR;
`else
  assign bus.ld_err = 1'b0;
`endif
endmodule
